rx_byte_fifo: RTL and testbench
===============================

Name: rx_byte_fifo

Overview:
Buffers bytes recovered by the UART receive datapath until the host side consumes them. Sits directly downstream of the receiver. It captures the parallel byte on each completed frame through an edge-detected write strobe, and presents it on a first-word-fall-through valid/ready read port. Reports fill level, full/empty and a sticky overrun flag when a frame arrives with no space.

Parameters:
DATA_W, 8, width of each stored byte/word
DEPTH, 8, number of entries; power of two, >= 2
ADDR_W, $clog2(DEPTH), derived pointer width; not to be overridden

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clr  input  1  synchronous flush: empties FIFO and clears overrun
wr_en  input  1  frame-complete strobe from receiver; level, may stay high for several cycles
wr_data  input  DATA_W  received byte, valid while wr_en high
rd_ready  input  1  consumer accepts head entry this cycle
rd_valid  output  1  head entry present
rd_data  output  DATA_W  head entry (FWFT)
count  output  ADDR_W+1  number of stored entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overrun  output  1  sticky: a write was dropped because FIFO was full
ovr_clr  input  1  synchronous clear of overrun only

Behaviour:
- Reset (reset=0, async): wr/rd pointers=0, count=0, overrun=0, edge register=0. Outputs: rd_valid=0, rd_data=0, full=0, empty=1. Storage array is not reset.
- Write event: push = wr_en & ~wr_en_q, where wr_en_q is wr_en registered each cycle. Exactly one write per strobe regardless of its length. wr_data is sampled in the push cycle.
- Pop event: pop = rd_valid & rd_ready. rd_ready while empty has no effect.
- Accept rule: push is stored if ~full, or if full & pop in the same cycle. If push & full & ~pop: data dropped, pointers unchanged, overrun<=1 at that edge.
- Storage: entry written at wr_ptr, wr_ptr<=wr_ptr+1. Pop advances rd_ptr<=rd_ptr+1. Both pointers wrap modulo DEPTH naturally (ADDR_W bits).
- count: +1 on accepted push without pop; -1 on pop without accepted push; unchanged on both or neither. Never exceeds DEPTH, never underflows.
- Empty + push + rd_ready same cycle: push stored, no pop (rd_valid was 0). count 0->1.
- Full + push + pop same cycle: both happen, count stays DEPTH, overrun unchanged.
- Latency: a byte pushed at edge N gives rd_valid=1 and rd_data=that byte from edge N onward (next cycle), if the FIFO was empty.
- FWFT: rd_data = mem[rd_ptr] when ~empty, else 0 (forced to zero for deterministic checking). rd_valid = ~empty.
- full/empty/count are derived from the registered count; no combinational path from wr_en/rd_ready to any status output.
- clr: highest priority after reset. At the edge, pointers=0, count=0, overrun=0. Any push/pop in that cycle is ignored. wr_en_q still updates, so a strobe held across clr does not re-write after clr drops.
- ovr_clr: clears overrun at the edge. If a dropped push occurs in the same cycle, set wins (overrun=1).
- Reset asserted mid-operation: immediate return to reset state; stored data is lost.

Test Plan:
- Reset then idle -> empty=1, rd_valid=0, rd_data=0, count=0, overrun=0.
- Push 0xA5 with wr_en held high 5 cycles, rd_ready=0 -> count=1 (single write), rd_valid=1 and rd_data=0xA5 one cycle after the rising edge.
- Push 0x01..0x08 (DEPTH=8), then pop with rd_ready=1 continuously -> full=1 after the 8th push; reads return 0x01..0x08 in order; empty=1 after the 8th pop. Repeat twice more to cover pointer wrap.
- Fill to 8, push 0x55 with rd_ready=0 -> 0x55 dropped, overrun=1, count=8; drain returns original 8 bytes; pulse ovr_clr -> overrun=0.
- Full, then push 0x99 and pop in the same cycle -> count stays 8, overrun=0, 0x99 is read last. Empty, then push 0x3C with rd_ready=1 -> count=1, 0x3C not consumed that cycle.
- Load 3 bytes with overrun set, pulse clr while wr_en is high -> count=0, empty=1, overrun=0, and no write occurs after clr deasserts until wr_en falls and rises again. Assert reset mid-fill -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO: the frame-complete strobe is edge-detected into a single
// push, and stored bytes are presented on a first-word-fall-through valid/ready port.
module rx_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en_q_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overrun_reg;

  logic push;
  logic pop;
  logic accept;
  logic drop;

  // Status comes only from the registered count, never from wr_en/rd_ready.
  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign overrun  = overrun_reg;
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg];

  assign push   = wr_en & ~wr_en_q_reg;
  assign pop    = rd_valid & rd_ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // Storage carries no reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (accept && !clr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q_reg <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      // The edge register keeps tracking during clr so a held strobe cannot re-fire.
      wr_en_q_reg <= wr_en;
      if (clr) begin
        wr_ptr_reg  <= '0;
        rd_ptr_reg  <= '0;
        count_reg   <= '0;
        overrun_reg <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
        end
        case ({accept, pop})
          2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
          2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
          default: count_reg <= count_reg;
        endcase
        // A drop in the same cycle as ovr_clr keeps the flag set.
        if (drop) begin
          overrun_reg <= 1'b1;
        end else if (ovr_clr) begin
          overrun_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboarded bench for rx_byte_fifo: stimulus queues expected bytes, a monitor
// pops and compares them on every accepted read.
module tb_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_ready;
  logic       ovr_clr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  rx_byte_fifo #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .full(full), .empty(empty), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle strobe per byte, followed by a low cycle to re-arm the edge detector.
  task automatic push_byte(input logic [7:0] d, input bit expect_store);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_store) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
    tick();
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  // Monitor: a read is accepted at the next rising edge when valid & ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && !clr && rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: got 0x%0h, expected no data", rd_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL read_data: got 0x%0h, expected 0x%0h", rd_data, e);
          end else begin
            $display("read 0x%0h ok", rd_data);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    rd_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_valid", 32'(rd_valid), 32'd0);
    chk("reset_data", 32'(rd_data), 32'h0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // Long strobe: exactly one write, visible the cycle after the push edge.
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    chk("a5_valid", 32'(rd_valid), 32'd1);
    chk("a5_data", 32'(rd_data), 32'hA5);
    wr_data = 8'h5A;
    repeat (4) tick();
    wr_en = 1'b0;
    tick();
    chk("a5_count_single", 32'(count), 32'd1);
    chk("a5_data_held", 32'(rd_data), 32'hA5);
    drain(1);
    chk("a5_empty", 32'(empty), 32'd1);

    // Fill/drain three times to exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd8);
      drain(8);
      chk("drain_empty", 32'(empty), 32'd1);
    end

    // Overrun: dropped byte, original contents intact, ovr_clr clears flag.
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b1);
    push_byte(8'h55, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd8);
    drain(8);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) push_byte(8'h20 + 8'(i), 1'b1);
    wr_en = 1'b1; wr_data = 8'h99; rd_ready = 1'b1; exp_q.push_back(8'h99);
    tick();
    wr_en = 1'b0; rd_ready = 1'b0;
    chk("fullpp_count", 32'(count), 32'd8);
    chk("fullpp_overrun", 32'(overrun), 32'd0);
    tick();
    drain(8);
    chk("fullpp_empty", 32'(empty), 32'd1);

    // Empty with push and rd_ready together: stored, not consumed.
    wr_en = 1'b1; wr_data = 8'h3C; rd_ready = 1'b1; exp_q.push_back(8'h3C);
    tick();
    rd_ready = 1'b0; wr_en = 1'b0;
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_data", 32'(rd_data), 32'h3C);
    tick();
    drain(1);

    // clr with overrun set, 3 bytes held and wr_en high across it.
    for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i), 1'b1);
    push_byte(8'hEE, 1'b0);
    drain(5);
    chk("preclr_count", 32'(count), 32'd3);
    chk("preclr_overrun", 32'(overrun), 32'd1);
    wr_en = 1'b1; wr_data = 8'h77; clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_overrun", 32'(overrun), 32'd0);
    repeat (2) tick();
    chk("clr_no_rewrite", 32'(count), 32'd0);
    wr_en = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'h78; exp_q.push_back(8'h78);
    tick();
    wr_en = 1'b0;
    chk("postclr_count", 32'(count), 32'd1);
    chk("postclr_data", 32'(rd_data), 32'h78);
    tick();

    // Asynchronous reset mid-fill, checked before the next clock edge.
    push_byte(8'h79, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_data", 32'(rd_data), 32'h0);
    chk("arst_full", 32'(full), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
